bin_map_reader: RTL and testbench
=================================

BIN_MAP_READER -- requirements
Module: bin_map_reader

Interface
REQ-001 Parameter IMG_W, default 128: pixels per row.
REQ-002 Parameter IMG_H, default 128: rows per frame.
REQ-003 Parameter BG, default 1'b1: background (non-edge) pixel value, forced on border pixels.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to stream one full binary frame.
REQ-007 b_rd  output  1  read strobe to the binary result memory.
REQ-008 b_addr  output  14  read address: row*IMG_W + col.
REQ-009 b_di  input  1  memory read data, valid exactly one cycle after b_rd.
REQ-010 o_valid  output  1  packed byte available on o_data.
REQ-011 o_ready  input  1  downstream accepts byte when o_valid && o_ready.
REQ-012 o_data  output  8  8 consecutive pixels; pixel at address base+i in bit i.
REQ-013 o_last  output  1  high with the final byte of the frame.
REQ-014 busy  output  1  high from start acceptance until done.
REQ-015 done  output  1  single-cycle pulse after the final byte handshake.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, SEND, FINISH.
REQ-017 IDLE -> FILL on start=1; start SHALL be ignored in any other state.
REQ-018 In FILL, b_rd SHALL be high for exactly 8 consecutive cycles, with b_addr = base, base+1, ..., base+7; base starts at 0 for each frame.
REQ-019 b_di SHALL be sampled in the cycle after each b_rd and placed into bit (addr - base) of the byte shift register.
REQ-020 A pixel whose row is 0 or IMG_H-1, or whose col is 0 or IMG_W-1, SHALL be stored as BG regardless of b_di; the read is still issued, so timing is uniform.
REQ-021 FILL -> SEND in the cycle after the 8th sample; o_valid SHALL be registered high on SEND entry.
REQ-022 Latency: start sampled at edge E0 -> b_rd high in cycles 1..8 -> o_valid high in cycle 10.
REQ-023 In SEND, o_data and o_last SHALL hold stable while o_valid=1 and o_ready=0; no reads SHALL be issued.
REQ-024 On handshake, o_valid SHALL drop the next cycle and base SHALL advance by 8 (14-bit, no wrap within a frame).
REQ-025 After the handshake, the FSM SHALL return to FILL, or go to FINISH if the handshaked byte had base = IMG_W*IMG_H-8 (16376 at defaults).
REQ-026 o_last SHALL be high only while o_valid is high for the final byte.
REQ-027 FINISH SHALL pulse done for one cycle, drop busy, and return to IDLE; base SHALL reset to 0.
REQ-028 Consecutive bytes SHALL be at least 10 cycles apart; a frame at defaults SHALL be exactly 2048 bytes.
REQ-029 If o_ready is already high on SEND entry, the handshake SHALL complete in that first SEND cycle.

Reset
REQ-030 On reset, the following SHALL apply at the next edge: state=IDLE, b_rd=0, b_addr=0, o_valid=0, o_data=0, o_last=0, busy=0, done=0, base=0.
REQ-031 Reset mid-frame SHALL abort the frame: no further b_rd, no done pulse, no o_valid until a new start.
REQ-032 Reset SHALL take priority over start when both are asserted in the same cycle.

Structure
REQ-033 Package bin_map_pkg SHALL hold IMG_W, IMG_H, ADDR_W=14, BG defaults and the state encoding.
REQ-034 Border detection SHALL be a combinational sub-module border_mask (inputs addr; output is_border), shared with other edge-map blocks.

Verification
REQ-035 Memory all 0s, o_ready=1, start at cycle 0 -> first o_valid at cycle 10; byte 0 = 8'hFF (row 0 border); byte 16 (row 1, cols 0-7) = 8'h01; 2048 bytes; o_last on byte 2047 only; one done pulse.
REQ-036 Memory checkerboard (b_di = addr[0]) -> interior bytes = 8'hAA, except col-0 bytes = 8'hAB and col-127 bytes = 8'hAA|8'h80.
REQ-037 o_ready held low 20 cycles on byte 5 -> o_data stable, b_rd low throughout, and byte 6 read starts the cycle after the handshake.
REQ-038 start pulsed again during FILL and during SEND -> ignored; byte count remains 2048.
REQ-039 Reset asserted at byte 100 mid-FILL -> all outputs at reset values next cycle, no done; a new start gives byte 0 again from address 0.

Source files
------------

// File: rtl/bin_map_pkg.sv
// Shared frame geometry, address width and FSM encoding for the binary edge-map readers.
package bin_map_pkg;
    localparam int   IMG_W  = 128;
    localparam int   IMG_H  = 128;
    localparam int   ADDR_W = 14;
    localparam logic BG     = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/border_mask.sv
// Flags addresses that fall on the outer ring of the image (first/last row or column).
module border_mask
    import bin_map_pkg::*;
#(
    parameter int IMG_W_P  = bin_map_pkg::IMG_W,
    parameter int IMG_H_P  = bin_map_pkg::IMG_H,
    parameter int ADDR_W_P = bin_map_pkg::ADDR_W
) (
    input  logic [ADDR_W_P-1:0] addr,
    output logic                is_border
);
    localparam logic [ADDR_W_P-1:0] W        = ADDR_W_P'(IMG_W_P);
    localparam logic [ADDR_W_P-1:0] ROW_LAST = ADDR_W_P'(IMG_H_P - 1);
    localparam logic [ADDR_W_P-1:0] COL_LAST = ADDR_W_P'(IMG_W_P - 1);

    logic [ADDR_W_P-1:0] row;
    logic [ADDR_W_P-1:0] col;

    always_comb begin
        row       = addr / W;
        col       = addr % W;
        is_border = (row == '0) || (row == ROW_LAST) ||
                    (col == '0) || (col == COL_LAST);
    end
endmodule

// File: rtl/bin_map_reader.sv
// Streams a binary frame out of result memory as packed bytes (pixel base+i in bit i),
// forcing the image border to the background value.
module bin_map_reader
    import bin_map_pkg::*;
#(
    parameter int   IMG_W_P = bin_map_pkg::IMG_W,
    parameter int   IMG_H_P = bin_map_pkg::IMG_H,
    parameter logic BG_P    = bin_map_pkg::BG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              b_rd,
    output logic [ADDR_W-1:0] b_addr,
    input  logic              b_di,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [7:0]        o_data,
    output logic              o_last,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(IMG_W_P * IMG_H_P - 8);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(8);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base;
    logic [2:0]        rd_idx;
    logic [2:0]        smp_cnt;
    logic              rd_vld_p1;
    logic              border_p1;
    logic              is_border;
    logic              pix_p1;
    logic              hs;
    logic              fill_done;
    logic              last_byte;

    border_mask #(
        .IMG_W_P  (IMG_W_P),
        .IMG_H_P  (IMG_H_P),
        .ADDR_W_P (ADDR_W)
    ) u_border_mask (
        .addr      (b_addr),
        .is_border (is_border)
    );

    always_comb begin
        hs        = o_valid && o_ready;
        last_byte = (base == LAST_BASE);
        fill_done = (state == FILL) && rd_vld_p1 && (smp_cnt == 3'd7);
        pix_p1    = border_p1 ? BG_P : b_di;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (fill_done) state_nxt = SEND;
            SEND:    if (hs) state_nxt = last_byte ? FINISH : FILL;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            b_rd      <= 1'b0;
            b_addr    <= '0;
            rd_idx    <= '0;
            smp_cnt   <= '0;
            rd_vld_p1 <= 1'b0;
            border_p1 <= 1'b0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            base      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;

            // Stage p0: issue eight sequential reads on every entry into FILL
            if (state != FILL && state_nxt == FILL) begin
                b_rd   <= 1'b1;
                b_addr <= (state == SEND) ? base + STEP : base;
                rd_idx <= '0;
            end else if (b_rd) begin
                if (rd_idx == 3'd7) begin
                    b_rd <= 1'b0;
                end else begin
                    b_addr <= b_addr + 1'b1;
                    rd_idx <= rd_idx + 3'd1;
                end
            end

            if (state == IDLE && start) busy <= 1'b1;

            // Stage p1: memory data returns; mask border and shift in from the top
            rd_vld_p1 <= b_rd;
            border_p1 <= is_border;
            if (state == FILL && rd_vld_p1) begin
                o_data  <= {pix_p1, o_data[7:1]};
                smp_cnt <= smp_cnt + 3'd1;
            end

            if (fill_done) begin
                o_valid <= 1'b1;
                o_last  <= last_byte;
            end

            if (state == SEND && hs) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
                if (last_byte) begin
                    base <= '0;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    base <= base + STEP;
                end
            end
        end
    end
endmodule

// File: tb/tb_bin_map_reader.sv
// Directed bench for bin_map_reader: memory model, byte capture monitor and hand-computed checks.
module tb_bin_map_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        b_rd;
    logic [13:0] b_addr;
    logic        b_di = 1'b0;
    logic        o_valid;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int mode  = 0;

    int cyc      = 0;
    int nbytes   = 0;
    int last_cnt = 0;
    int last_idx = -1;
    int done_cnt = 0;
    int bad_last = 0;
    int min_gap  = 1000000;
    int last_hs  = -1000000;
    logic [7:0] cap [0:8191];

    always #5 clk = ~clk;

    bin_map_reader dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .b_rd    (b_rd),
        .b_addr  (b_addr),
        .b_di    (b_di),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .busy    (busy),
        .done    (done)
    );

    // Memory returns data one cycle after the address; mode 1 is a checkerboard
    always @(posedge clk) b_di <= (mode == 1) ? b_addr[0] : 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_last && !o_valid) bad_last <= bad_last + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (o_valid && o_ready) begin
            if (nbytes < 8192) cap[nbytes] <= o_data;
            if (o_last) begin
                last_cnt <= last_cnt + 1;
                last_idx <= nbytes;
            end
            if (cyc - last_hs < min_gap) min_gap <= cyc - last_hs;
            last_hs <= cyc;
            nbytes  <= nbytes + 1;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int limit);
        int k = 0;
        while (nbytes < n && k < limit) begin
            step();
            k++;
        end
        if (nbytes < n) chk_val("wait_bytes_timeout", nbytes, n);
    endtask

    task automatic wait_done(input int d, input int limit);
        int k = 0;
        while (done_cnt < d && k < limit) begin
            step();
            k++;
        end
        if (done_cnt < d) chk_val("wait_done_timeout", done_cnt, d);
    endtask

    initial begin
        int n0;
        int n1;
        int d0;
        int l0;
        int k;
        int flag;
        logic [7:0] d5;

        reset   = 1'b1;
        start   = 1'b1;
        o_ready = 1'b1;
        mode    = 0;
        repeat (3) step();
        chk_val("rst_b_rd",    b_rd,    0);
        chk_val("rst_b_addr",  b_addr,  0);
        chk_val("rst_o_valid", o_valid, 0);
        chk_val("rst_o_data",  o_data,  0);
        chk_val("rst_o_last",  o_last,  0);
        chk_val("rst_busy",    busy,    0);
        chk_val("rst_done",    done,    0);
        reset = 1'b0;
        start = 1'b0;
        step();
        chk_val("rst_over_start_busy", busy, 0);

        // Frame A: all-zero memory, always ready
        n0 = nbytes; d0 = done_cnt; l0 = last_cnt;
        pulse_start();
        chk_val("a_rd_first",   b_rd,   1);
        chk_val("a_addr_first", b_addr, 0);
        chk_val("a_busy",       busy,   1);
        repeat (7) step();
        chk_val("a_rd_8th",   b_rd,   1);
        chk_val("a_addr_8th", b_addr, 7);
        step();
        chk_val("a_rd_off",     b_rd,    0);
        chk_val("a_valid_early", o_valid, 0);
        step();
        chk_val("a_valid_c10", o_valid, 1);
        chk_val("a_byte0_now", o_data,  8'hFF);
        wait_done(d0 + 1, 25000);
        chk_val("a_count",    nbytes - n0, 2048);
        chk_val("a_byte0",    cap[n0],        8'hFF);
        chk_val("a_byte16",   cap[n0 + 16],   8'h01);
        chk_val("a_byte31",   cap[n0 + 31],   8'h80);
        chk_val("a_byte1000", cap[n0 + 1000], 8'h00);
        chk_val("a_byte2047", cap[n0 + 2047], 8'hFF);
        chk_val("a_last_cnt", last_cnt - l0, 1);
        chk_val("a_last_idx", last_idx, n0 + 2047);
        step();
        chk_val("a_busy_end", busy, 0);
        chk_val("a_done_one", done_cnt - d0, 1);
        chk_val("a_last_w_valid", bad_last, 0);
        chk_val("a_min_gap_ok", (min_gap >= 10), 1);

        // Frame B: checkerboard, stall on byte 5, stray starts
        mode = 1;
        n0 = nbytes; d0 = done_cnt;
        pulse_start();
        wait_bytes(n0 + 5, 200);
        o_ready = 1'b0;
        k = 0;
        while (!o_valid && k < 20) begin
            step();
            k++;
        end
        chk_val("b_byte5_valid", o_valid, 1);
        d5 = o_data;
        flag = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) start = 1'b1;
            step();
            start = 1'b0;
            if (o_data !== d5 || b_rd !== 1'b0 || o_valid !== 1'b1) flag++;
        end
        chk_val("b_stall_stable", flag, 0);
        chk_val("b_byte5", d5, 8'hFF);
        o_ready = 1'b1;
        step();
        chk_val("b_valid_drop", o_valid, 0);
        chk_val("b_rd_resume",  b_rd,    1);
        chk_val("b_addr_48",    b_addr,  48);
        pulse_start();
        wait_done(d0 + 1, 25000);
        chk_val("b_count",    nbytes - n0, 2048);
        chk_val("b_byte0",    cap[n0],        8'hFF);
        chk_val("b_byte16",   cap[n0 + 16],   8'hAB);
        chk_val("b_byte17",   cap[n0 + 17],   8'hAA);
        chk_val("b_byte31",   cap[n0 + 31],   8'hAA);
        chk_val("b_byte1000", cap[n0 + 1000], 8'hAA);
        chk_val("b_byte2040", cap[n0 + 2040], 8'hFF);
        chk_val("b_done_one", done_cnt - d0, 1);

        // Frame C: reset in the middle of a fill, then restart
        mode = 0;
        n0 = nbytes;
        pulse_start();
        wait_bytes(n0 + 100, 1500);
        repeat (3) step();
        chk_val("c_in_fill", b_rd, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_val("c_rst_b_rd",    b_rd,    0);
        chk_val("c_rst_b_addr",  b_addr,  0);
        chk_val("c_rst_o_valid", o_valid, 0);
        chk_val("c_rst_o_data",  o_data,  0);
        chk_val("c_rst_busy",    busy,    0);
        chk_val("c_rst_done",    done,    0);
        d0 = done_cnt;
        flag = 0;
        repeat (40) begin
            step();
            if (b_rd || o_valid || busy) flag++;
        end
        chk_val("c_quiet_after_rst", flag, 0);
        chk_val("c_no_done", done_cnt, d0);
        n1 = nbytes;
        pulse_start();
        chk_val("c_restart_rd",   b_rd,   1);
        chk_val("c_restart_addr", b_addr, 0);
        wait_bytes(n1 + 1, 50);
        chk_val("c_restart_byte0", cap[n1], 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
